// File: rtl/cart_mem_arbiter.sv
// Arbitrates the cartridge memory port between the ROM loader and two slot mappers.
// Optional WAIT-state watchdog enabled by defining CART_ARB_TIMEOUT_EN.
module cart_mem_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              c0_req,
  input  logic              c0_wr,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [7:0]        c0_din,
  output logic [7:0]        c0_dout,
  output logic              c0_ack,
  input  logic              c1_req,
  input  logic              c1_wr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [7:0]        c1_din,
  output logic [7:0]        c1_dout,
  output logic              c1_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic [1:0] G_LD = 2'd0, G_C0 = 2'd1, G_C1 = 2'd2;

  state_t     state;
  logic [1:0] gnt, nxt_gnt;
  logic       rr_c1;      // set: c1 wins the next c0/c1 tie
  logic       any_req;
  logic       timeout_hit;
  logic       done;
  logic [7:0] rd_val;

  always_comb begin
    nxt_gnt = G_C0;
    if (ld_req)                nxt_gnt = G_LD;
    else if (c0_req && c1_req) nxt_gnt = rr_c1 ? G_C1 : G_C0;
    else if (c1_req)           nxt_gnt = G_C1;
  end

  assign any_req = ld_req | c0_req | c1_req;

`ifdef CART_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] wait_cnt;
  assign timeout_hit = (state == WAIT) && !mem_ready && (wait_cnt == TO_LIM);
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done   = (state == WAIT) && (mem_ready || timeout_hit);
  // A timed-out read returns all ones so the mapper sees open bus.
  assign rd_val = mem_ready ? mem_dout : 8'hFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= G_LD;
      rr_c1    <= 1'b0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      ld_ack   <= 1'b0;
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      c0_dout  <= '0;
      c1_dout  <= '0;
      busy     <= 1'b0;
`ifdef CART_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      mem_req <= 1'b0;
      ld_ack  <= 1'b0;
      c0_ack  <= 1'b0;
      c1_ack  <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          gnt     <= nxt_gnt;
          mem_req <= 1'b1;
          busy    <= 1'b1;
          state   <= ISSUE;
          case (nxt_gnt)
            G_LD: begin mem_addr <= ld_addr; mem_din <= ld_data; mem_wr <= 1'b1;  end
            G_C0: begin mem_addr <= c0_addr; mem_din <= c0_din;  mem_wr <= c0_wr; end
            default: begin mem_addr <= c1_addr; mem_din <= c1_din; mem_wr <= c1_wr; end
          endcase
        end
        ISSUE: begin
          state <= WAIT;
`ifdef CART_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (done) begin
          state <= ACK;
          case (gnt)
            G_LD: ld_ack <= 1'b1;
            G_C0: begin c0_ack <= 1'b1; if (!mem_wr) c0_dout <= rd_val; end
            default: begin c1_ack <= 1'b1; if (!mem_wr) c1_dout <= rd_val; end
          endcase
`ifdef CART_ARB_TIMEOUT_EN
          if (timeout_hit) timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
`endif
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (gnt == G_C0)      rr_c1 <= 1'b1;
          else if (gnt == G_C1) rr_c1 <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: directed transactions push expected memory
// commands and acks; a negedge monitor pops and compares them.
module tb_cart_mem_arbiter;

  logic        clk = 0;
  logic        reset = 1;
  logic        ld_req = 0, c0_req = 0, c1_req = 0;
  logic        c0_wr = 0, c1_wr = 0;
  logic [24:0] ld_addr = 0, c0_addr = 0, c1_addr = 0;
  logic [7:0]  ld_data = 0, c0_din = 0, c1_din = 0;
  logic [7:0]  c0_dout, c1_dout;
  logic        ld_ack, c0_ack, c1_ack;
  logic        mem_req, mem_wr, mem_ready, busy, timeout_err;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 0;
  logic        model_ready = 0, force_ready = 0;

  assign mem_ready = model_ready | force_ready;

  cart_mem_arbiter #(.ADDR_W(25), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_din(c0_din),
    .c0_dout(c0_dout), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_din(c1_din),
    .c1_dout(c1_dout), .c1_ack(c1_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [24:0] addr; logic [7:0] din; } cmd_t;
  typedef struct { int ch; logic [7:0] dout; } ack_t;

  cmd_t exp_cmd[$];
  ack_t exp_ack[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   mem_lat = 1;
  bit   mem_en = 1;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] mem_val(input logic [24:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory model: answers each command mem_lat cycles after the strobe.
  initial begin
    logic [24:0] a;
    forever begin
      @(negedge clk);
      if (mem_req && mem_en && !reset) begin
        a = mem_addr;
        repeat (mem_lat) @(posedge clk);
        #1 model_ready = 1; mem_dout = mem_val(a);
        @(posedge clk);
        #1 model_ready = 0;
      end
    end
  end

  // Monitor / scoreboard
  cmd_t       mc;
  ack_t       ma;
  logic [2:0] acks, prev_acks = 0;
  logic       prev_req = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        chk("mem_req_width", {31'd0, prev_req}, 0);
        if (exp_cmd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_mem_req: addr %0h, required no command", mem_addr);
        end else begin
          mc = exp_cmd.pop_front();
          chk("mem_wr", {31'd0, mem_wr}, {31'd0, mc.wr});
          chk("mem_addr", {7'd0, mem_addr}, {7'd0, mc.addr});
          chk("mem_din", {24'd0, mem_din}, {24'd0, mc.din});
        end
      end
      acks = {c1_ack, c0_ack, ld_ack};
      if (acks != 0) begin
        chk("ack_onehot", $countones(acks), 1);
        chk("ack_width", {29'd0, acks & prev_acks}, 0);
        if (exp_ack.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: acks %0b, required none", acks);
        end else begin
          ma = exp_ack.pop_front();
          chk("ack_channel", {29'd0, acks}, 32'd1 << ma.ch);
          if (ma.ch == 1) chk("c0_dout", {24'd0, c0_dout}, {24'd0, ma.dout});
          if (ma.ch == 2) chk("c1_dout", {24'd0, c1_dout}, {24'd0, ma.dout});
        end
      end
      prev_acks = acks;
      prev_req  = mem_req;
    end else begin
      prev_acks = 0;
      prev_req  = 0;
    end
  end

  // Requester: raise req, wait (bounded) for ack, drop req on the next edge.
  task automatic xfer(input int ch, input logic wr, input logic [24:0] a,
                      input logic [7:0] d, output int acyc);
    bit got = 0;
    case (ch)
      0: begin ld_req = 1; ld_addr = a; ld_data = d; end
      1: begin c0_req = 1; c0_wr = wr; c0_addr = a; c0_din = d; end
      default: begin c1_req = 1; c1_wr = wr; c1_addr = a; c1_din = d; end
    endcase
    acyc = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if ((ch == 0 && ld_ack) || (ch == 1 && c0_ack) || (ch == 2 && c1_ack)) begin
        got = 1; acyc = cyc;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL xfer_timeout ch%0d: no ack in 300 cycles, required ack", ch);
    end
    @(posedge clk);
    #1;
    case (ch)
      0: ld_req = 0;
      1: c0_req = 0;
      default: c1_req = 0;
    endcase
  endtask

  task automatic push(input logic wr, input logic [24:0] a, input logic [7:0] d,
                      input int ch, input logic [7:0] dout);
    exp_cmd.push_back('{wr, a, d});
    exp_ack.push_back('{ch, dout});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_acks", {29'd0, ld_ack, c0_ack, c1_ack}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    chk("rst_mem_addr", {7'd0, mem_addr}, 0);
    chk("rst_mem_din", {24'd0, mem_din}, 0);
    chk("rst_douts", {16'd0, c0_dout, c1_dout}, 0);
    exp_cmd.delete();
    exp_ack.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ac, ac0, ac1, acl;
    do_reset();

    // Single c0 read, memory answers two cycles after the strobe
    mem_lat = 2;
    push(0, 25'h0004000, 8'h00, 1, 8'hA5);
    t0 = cyc;
    xfer(1, 0, 25'h0004000, 8'h00, ac);
    chk("c0_read_latency", ac - t0, 4);
    repeat (2) @(negedge clk);
    chk("busy_after_read", {31'd0, busy}, 0);

    // Contention: fresh RR pointer grants c0 first, then alternates
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 25'h0000100 + 25'(i), 8'h00, 1, mem_val(25'h0000100 + 25'(i)));
      push(0, 25'h0000200 + 25'(i), 8'h00, 2, mem_val(25'h0000200 + 25'(i)));
    end
    fork
      begin int a; for (int i = 0; i < 4; i++) xfer(1, 0, 25'h0000100 + 25'(i), 8'h00, a); end
      begin int a; for (int i = 0; i < 4; i++) xfer(2, 0, 25'h0000200 + 25'(i), 8'h00, a); end
    join

    // Loader beats both slots; slots then resume in RR order (c0 next)
    push(1, 25'h0010000, 8'h3C, 0, 8'h00);
    push(1, 25'h0000300, 8'h5E, 1, 8'hA6);
    push(0, 25'h0000401, 8'h00, 2, 8'hA4);
    fork
      xfer(0, 0, 25'h0010000, 8'h3C, acl);
      xfer(1, 1, 25'h0000300, 8'h5E, ac0);
      xfer(2, 0, 25'h0000401, 8'h00, ac1);
    join
    chk("order_ld_before_c0", {31'd0, acl < ac0}, 1);
    chk("order_c0_before_c1", {31'd0, ac0 < ac1}, 1);

    // Reset during WAIT abandons the transaction; late mem_ready ignored
    mem_en = 0;
    exp_cmd.push_back('{1'b0, 25'h0000AB0, 8'h00});
    c0_req = 1; c0_wr = 0; c0_addr = 25'h0000AB0; c0_din = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_in_wait", {31'd0, busy}, 1);
    reset = 1; c0_req = 0;
    #1;
    chk("wait_rst_busy", {31'd0, busy}, 0);
    chk("wait_rst_mem_req", {31'd0, mem_req}, 0);
    chk("wait_rst_c0_ack", {31'd0, c0_ack}, 0);
    chk("wait_rst_c0_dout", {24'd0, c0_dout}, 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1 force_ready = 1;
    @(posedge clk); #1 force_ready = 0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_late_ready", {31'd0, busy}, 0);
    end
    mem_en = 1;
    @(posedge clk);
    #1;

    // c1 write leaves c1_dout alone; the following read updates it
    push(1, 25'h0000055, 8'h77, 2, 8'h00);
    xfer(2, 1, 25'h0000055, 8'h77, ac);
    chk("c1_dout_after_write", {24'd0, c1_dout}, 0);
    push(0, 25'h0001234, 8'h00, 2, 8'h91);
    xfer(2, 0, 25'h0001234, 8'h00, ac);
    chk("c1_dout_after_read", {24'd0, c1_dout}, 32'h91);

`ifdef CART_ARB_TIMEOUT_EN
    mem_en = 0;
    push(0, 25'h0000777, 8'h00, 1, 8'hFF);
    t0 = cyc;
    xfer(1, 0, 25'h0000777, 8'h00, ac);
    chk("timeout_ack_late", {31'd0, (ac - t0) > 16}, 1);
    chk("timeout_err_set", {31'd0, timeout_err}, 1);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", {31'd0, timeout_err}, 1);
    mem_en = 1;
    do_reset();
`else
    chk("timeout_err_tied", {31'd0, timeout_err}, 0);
`endif

    repeat (3) @(negedge clk);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("ack_queue_drained", exp_ack.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
